obi_wb_arbiter: RTL and testbench

- Shares the single Wishbone classic master bus between the core's two OBI ports: instruction fetch (read-only) and load/store.
- Sits between the core and the Controller's core bus inside processorci_top.
- Allows one outstanding transaction in total, with round-robin arbitration on ties.
- A watchdog returns an OBI error response if the bus never acknowledges.

---
 rtl/obi_wb_arbiter_if.sv | 45 ++++
 rtl/obi_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_obi_wb_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_wb_arbiter_if.sv
// obi_wb_arbiter_if -- signal bundle between the core's two OBI ports, the
// arbiter, and the shared Wishbone classic master bus.
//   master : arbiter side. Takes the OBI requests and Wishbone slave responses.
//            Drives the OBI grants and responses and the Wishbone request lines.
//   slave  : environment side (core OBI ports plus Wishbone slave), the mirror image.
// Signals:
//   instr_* : fetch port (req/gnt/addr, rvalid/err/rdata)
//   data_*  : load/store port (req/gnt/we/be/addr/wdata, rvalid/err/rdata)
//   wb_*    : Wishbone classic (cyc/stb/we/adr/dat_o/sel out, dat_i/ack in)
interface obi_wb_arbiter_if;
  logic        instr_req_i, instr_gnt_o;
  logic [31:0] instr_addr_i;
  logic        instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;

  logic        data_req_i, data_gnt_o, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;

  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  wb_dat_i, wb_ack_i,
    output instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );

  modport slave (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output wb_dat_i, wb_ack_i,
    input  instr_gnt_o, instr_rvalid_o, instr_err_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
  );
endinterface

// File: rtl/obi_wb_arbiter.sv
// obi_wb_arbiter -- shares one Wishbone classic master bus between the core's
// instruction-fetch and load/store OBI ports. At most one transaction is
// outstanding. Simultaneous requests alternate round-robin. A watchdog turns a
// bus that never acks into an OBI error response.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : obi_wb_arbiter_if.master (OBI ports + Wishbone master)
// Parameters:
//   TIMEOUT_CYCLES : max cycles with cyc high waiting for ack; 0 disables
module obi_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  obi_wb_arbiter_if.master  bus
);
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);
  localparam int          CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUS} state_t;

  state_t        state_q, state_d;
  logic          owner_q, last_q;        // 1 = data port, 0 = instruction port
  logic [31:0]   adr_q, dat_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   instr_rdata_q, data_rdata_q;
  logic          instr_rvalid_q, instr_err_q, data_rvalid_q, data_err_q;

  logic          gnt_i, gnt_d, ack, tmo;
  logic [31:0]   req_adr;

  // Next state plus the combinational grant decision. Grants are gated by
  // rst_n so they read 0 for the whole reset, not just after the first edge.
  always_comb begin
    state_d = state_q;
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    ack     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n) begin
          // On a tie the port that did not win last time goes first.
          gnt_d = bus.data_req_i  & (~bus.instr_req_i | ~last_q);
          gnt_i = bus.instr_req_i & (~bus.data_req_i  |  last_q);
        end
        if (gnt_i | gnt_d) state_d = BUS;
      end
      BUS: begin
        ack = bus.wb_ack_i;
        // Ack in the final watchdog cycle still counts as a good response.
        tmo = WD_EN && !ack && (cnt_q == CNT_LAST);
        if (ack | tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign req_adr = gnt_d ? bus.data_addr_i : bus.instr_addr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q        <= 1'b0;
      last_q         <= 1'b0;
      adr_q          <= '0;
      dat_q          <= '0;
      we_q           <= 1'b0;
      sel_q          <= '0;
      cnt_q          <= '0;
      instr_rdata_q  <= '0;
      data_rdata_q   <= '0;
      instr_rvalid_q <= 1'b0;
      instr_err_q    <= 1'b0;
      data_rvalid_q  <= 1'b0;
      data_err_q     <= 1'b0;
    end else begin
      // Responses are single-cycle pulses.
      instr_rvalid_q <= 1'b0;
      instr_err_q    <= 1'b0;
      data_rvalid_q  <= 1'b0;
      data_err_q     <= 1'b0;

      if (gnt_i | gnt_d) begin
        owner_q <= gnt_d;
        last_q  <= gnt_d;
        cnt_q   <= '0;
        adr_q   <= req_adr & 32'hFFFF_FFFC;
        we_q    <= gnt_d & bus.data_we_i;
        sel_q   <= gnt_d ? bus.data_be_i : 4'hF;
        dat_q   <= gnt_d ? bus.data_wdata_i : 32'h0;
      end

      if (state_q == BUS) begin
        cnt_q <= cnt_q + 1'b1;
        if (ack | tmo) begin
          if (owner_q) begin
            data_rvalid_q <= 1'b1;
            data_err_q    <= tmo;
            data_rdata_q  <= ack ? bus.wb_dat_i : 32'h0;
          end else begin
            instr_rvalid_q <= 1'b1;
            instr_err_q    <= tmo;
            instr_rdata_q  <= ack ? bus.wb_dat_i : 32'h0;
          end
        end
      end
    end
  end

  assign bus.instr_gnt_o    = gnt_i;
  assign bus.data_gnt_o     = gnt_d;
  assign bus.instr_rvalid_o = instr_rvalid_q;
  assign bus.instr_err_o    = instr_err_q;
  assign bus.instr_rdata_o  = instr_rdata_q;
  assign bus.data_rvalid_o  = data_rvalid_q;
  assign bus.data_err_o     = data_err_q;
  assign bus.data_rdata_o   = data_rdata_q;
  assign bus.wb_cyc_o       = (state_q == BUS);
  assign bus.wb_stb_o       = (state_q == BUS);
  assign bus.wb_we_o        = we_q;
  assign bus.wb_adr_o       = adr_q;
  assign bus.wb_dat_o       = dat_q;
  assign bus.wb_sel_o       = sel_q;
endmodule

// File: tb/tb_obi_wb_arbiter.sv
// tb_obi_wb_arbiter -- directed scenarios plus a randomized run checked
// against a transaction-level model of the arbiter.
module tb_obi_wb_arbiter;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  obi_wb_arbiter_if bus();
  obi_wb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.instr_req_i = 1'b0; bus.instr_addr_i = '0;
    bus.data_req_i = 1'b0;  bus.data_we_i = 1'b0; bus.data_be_i = '0;
    bus.data_addr_i = '0;   bus.data_wdata_i = '0;
    bus.wb_dat_i = '0;      bus.wb_ack_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.instr_req_i = 1'b1; bus.data_req_i = 1'b1;
    bus.wb_ack_i = 1'b1;    bus.wb_dat_i = 32'hDEAD_BEEF;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.instr_gnt_o, bus.data_gnt_o,
         bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.data_err_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000000", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
               bus.instr_gnt_o, bus.data_gnt_o, bus.instr_rvalid_o, bus.instr_err_o,
               bus.data_rvalid_o, bus.data_err_o});
    end
    checks++;
    if ({bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.instr_rdata_o, bus.data_rdata_o} !== '0) begin
      errors++;
      $display("FAIL reset_data got adr=%h dat=%h sel=%h ir=%h dr=%h want all 0", bus.wb_adr_o,
               bus.wb_dat_o, bus.wb_sel_o, bus.instr_rdata_o, bus.data_rdata_o);
    end
    do_reset();
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0104;
    @(negedge clk);
    checks++;
    if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b10) begin
      errors++; $display("FAIL fetch_gnt got %b want 10", {bus.instr_gnt_o, bus.data_gnt_o});
    end
    next_cycle();
    bus.instr_req_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0041_0113;
    @(negedge clk);
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o} !== {3'b110, 4'hF, 32'h0000_0104}) begin
      errors++;
      $display("FAIL fetch_bus got cyc=%b stb=%b we=%b sel=%h adr=%h want 1 1 0 f 00000104",
               bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o);
    end
    next_cycle();
    bus.wb_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.wb_cyc_o} !== 4'b1000 ||
        bus.instr_rdata_o !== 32'h0041_0113) begin
      errors++;
      $display("FAIL fetch_resp got rv=%b err=%b drv=%b cyc=%b rdata=%h want 1 0 0 0 00410113",
               bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.wb_cyc_o, bus.instr_rdata_o);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (bus.instr_rvalid_o !== 1'b0 || bus.instr_rdata_o !== 32'h0041_0113) begin
      errors++;
      $display("FAIL fetch_pulse got rv=%b rdata=%h want 0 00410113", bus.instr_rvalid_o, bus.instr_rdata_o);
    end
  endtask

  task automatic test_tie();
    logic exp_d, prev_d;
    do_reset();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_1000;
    bus.data_req_i  = 1'b1; bus.data_addr_i  = 32'h0000_2000; bus.data_be_i = 4'hF;
    exp_d = 1'b1; prev_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wb_ack_i = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.instr_gnt_o, bus.data_gnt_o} !== (exp_d ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL tie_gnt%0d got %b want %b", i, {bus.instr_gnt_o, bus.data_gnt_o}, exp_d ? 2'b01 : 2'b10);
      end
      if (i > 0) begin
        checks++;
        if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== (prev_d ? 2'b01 : 2'b10) ||
            (prev_d ? bus.data_rdata_o : bus.instr_rdata_o) !== 32'hA0 + i - 1) begin
          errors++;
          $display("FAIL tie_resp%0d got irv=%b drv=%b ir=%h dr=%h want owner=%b data=%h", i,
                   bus.instr_rvalid_o, bus.data_rvalid_o, bus.instr_rdata_o, bus.data_rdata_o,
                   prev_d, 32'hA0 + i - 1);
        end
      end
      next_cycle();
      bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hA0 + i;
      @(negedge clk);
      checks++;
      if ({bus.wb_cyc_o, bus.instr_gnt_o, bus.data_gnt_o} !== 3'b100) begin
        errors++;
        $display("FAIL tie_bus%0d got cyc/ig/dg=%b want 100", i, {bus.wb_cyc_o, bus.instr_gnt_o, bus.data_gnt_o});
      end
      next_cycle();
      prev_d = exp_d; exp_d = ~exp_d;
    end
    bus.wb_ack_i = 1'b0; bus.instr_req_i = 1'b0; bus.data_req_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.instr_rvalid_o, bus.data_rvalid_o} !== 2'b10 || bus.instr_rdata_o !== 32'hA3) begin
      errors++;
      $display("FAIL tie_last got irv=%b drv=%b ir=%h want 1 0 000000a3", bus.instr_rvalid_o,
               bus.data_rvalid_o, bus.instr_rdata_o);
    end
  endtask

  task automatic test_byte_store();
    do_reset();
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'b0100;
    bus.data_addr_i = 32'h0000_2003; bus.data_wdata_i = 32'h00AB_0000;
    @(negedge clk);
    checks++;
    if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b01) begin
      errors++; $display("FAIL store_gnt got %b want 01", {bus.instr_gnt_o, bus.data_gnt_o});
    end
    next_cycle();
    bus.data_req_i = 1'b0; bus.data_wdata_i = 32'hFFFF_FFFF;
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if ({bus.wb_cyc_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o} !==
        {2'b11, 4'b0100, 32'h0000_2000, 32'h00AB_0000}) begin
      errors++;
      $display("FAIL store_bus got cyc=%b we=%b sel=%b adr=%h dat=%h want 1 1 0100 00002000 00ab0000",
               bus.wb_cyc_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o);
    end
    next_cycle();
    bus.wb_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o} !== 3'b100 || bus.data_rdata_o !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_resp got drv=%b derr=%b irv=%b dr=%h want 1 0 0 12345678",
               bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o, bus.data_rdata_o);
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    bus.data_req_i = 1'b1; bus.data_we_i = 1'b1; bus.data_be_i = 4'b0011;
    bus.data_addr_i = 32'h0000_3009; bus.data_wdata_i = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if (bus.data_gnt_o !== 1'b1) begin errors++; $display("FAIL wait_gnt got %b want 1", bus.data_gnt_o); end
    next_cycle();
    // Competing request and changed data-port fields while the bus is busy.
    bus.data_req_i = 1'b0; bus.data_addr_i = 32'hFFFF_FFFF; bus.data_wdata_i = 32'h0;
    bus.data_be_i = 4'h0; bus.data_we_i = 1'b0;
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0500;
    for (int w = 0; w < 5; w++) begin
      @(negedge clk);
      checks++;
      if ({bus.wb_cyc_o, bus.wb_we_o, bus.instr_gnt_o, bus.data_gnt_o, bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o} !==
          {4'b1100, 4'b0011, 32'h0000_3008, 32'h5555_AAAA} || bus.data_rvalid_o !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold%0d got cyc=%b we=%b ig=%b dg=%b sel=%b adr=%h dat=%h drv=%b", w,
                 bus.wb_cyc_o, bus.wb_we_o, bus.instr_gnt_o, bus.data_gnt_o, bus.wb_sel_o,
                 bus.wb_adr_o, bus.wb_dat_o, bus.data_rvalid_o);
      end
      next_cycle();
    end
    bus.instr_req_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hCAFE_0001;
    @(negedge clk);
    next_cycle();
    bus.wb_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.data_rvalid_o, bus.data_err_o, bus.wb_cyc_o} !== 3'b100 || bus.data_rdata_o !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL wait_resp got drv=%b derr=%b cyc=%b dr=%h want 1 0 0 cafe0001",
               bus.data_rvalid_o, bus.data_err_o, bus.wb_cyc_o, bus.data_rdata_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h0000_4000; bus.data_be_i = 4'hF;
    @(negedge clk);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      bus.data_req_i = 1'b0;
      @(negedge clk);
      if (!bus.wb_cyc_o) break;
      n++;
    end
    checks++;
    if (n !== TMO) begin errors++; $display("FAIL tmo_len got %0d want %0d", n, TMO); end
    checks++;
    if ({bus.data_rvalid_o, bus.data_err_o, bus.instr_rvalid_o} !== 3'b110 || bus.data_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL tmo_resp got drv=%b derr=%b irv=%b dr=%h want 1 1 0 0", bus.data_rvalid_o,
               bus.data_err_o, bus.instr_rvalid_o, bus.data_rdata_o);
    end
    next_cycle();
    bus.instr_req_i = 1'b1; bus.instr_addr_i = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if ({bus.data_rvalid_o, bus.data_err_o, bus.instr_gnt_o} !== 3'b001) begin
      errors++;
      $display("FAIL tmo_after got drv=%b derr=%b ig=%b want 0 0 1", bus.data_rvalid_o, bus.data_err_o, bus.instr_gnt_o);
    end
    next_cycle();
    bus.instr_req_i = 1'b0; bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0BAD_F00D;
    next_cycle();
    bus.wb_ack_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.instr_rvalid_o, bus.instr_err_o} !== 2'b10 || bus.instr_rdata_o !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL tmo_next got irv=%b ierr=%b ir=%h want 1 0 0badf00d", bus.instr_rvalid_o,
               bus.instr_err_o, bus.instr_rdata_o);
    end
  endtask

  task automatic test_reset_mid_bus();
    do_reset();
    bus.data_req_i = 1'b1; bus.data_addr_i = 32'h0000_5004; bus.data_be_i = 4'hF;
    next_cycle();
    bus.data_req_i = 1'b0;
    #2;
    checks++;
    if (bus.wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rstmid_busy got cyc=%b want 1", bus.wb_cyc_o); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_adr_o, bus.wb_sel_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_drop got cyc=%b stb=%b adr=%h sel=%h want 0 0 0 0", bus.wb_cyc_o,
               bus.wb_stb_o, bus.wb_adr_o, bus.wb_sel_o);
    end
    next_cycle();
    rst_n = 1'b1;
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h7777_7777;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.data_rvalid_o, bus.instr_rvalid_o, bus.wb_cyc_o} !== 3'b000) begin
        errors++;
        $display("FAIL rstmid_quiet%0d got drv=%b irv=%b cyc=%b want 000", c, bus.data_rvalid_o,
                 bus.instr_rvalid_o, bus.wb_cyc_o);
      end
      next_cycle();
    end
    bus.wb_ack_i = 1'b0; bus.instr_req_i = 1'b1; bus.data_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.instr_gnt_o, bus.data_gnt_o} !== 2'b01) begin
      errors++; $display("FAIL rstmid_tie got %b want 01", {bus.instr_gnt_o, bus.data_gnt_o});
    end
    next_cycle();
    idle_inputs(); bus.wb_ack_i = 1'b1;
    next_cycle();
    bus.wb_ack_i = 1'b0;
  endtask

  // Transaction-level model: one job in flight, slave latency chosen per job
  // (0 = never ack), responses one cycle after completion.
  task automatic test_random();
    logic        m_busy, m_owner, m_last, m_we, eg_i, eg_d, r_v, r_o, r_e;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic [31:0] m_rdata [2];
    int          m_cnt, m_lat;
    do_reset();
    m_busy = 0; m_owner = 0; m_last = 0; m_we = 0; m_adr = '0; m_dat = '0; m_sel = '0;
    m_rdata[0] = '0; m_rdata[1] = '0; m_cnt = 0; m_lat = 0; r_v = 0; r_o = 0; r_e = 0;
    for (int t = 0; t < 600; t++) begin
      if (!bus.instr_req_i && $urandom_range(2) == 0) begin
        bus.instr_req_i = 1'b1; bus.instr_addr_i = $urandom;
      end
      if (!bus.data_req_i && $urandom_range(2) == 0) begin
        bus.data_req_i = 1'b1; bus.data_we_i = 1'($urandom_range(1)); bus.data_be_i = 4'($urandom);
        bus.data_addr_i = $urandom; bus.data_wdata_i = $urandom;
      end
      bus.wb_dat_i = $urandom;
      if (m_busy) bus.wb_ack_i = (m_lat != 0) && (m_cnt + 1 == m_lat);
      else        bus.wb_ack_i = ($urandom_range(3) == 0);
      @(negedge clk);
      eg_i = 0; eg_d = 0;
      if (!m_busy) begin
        if (bus.instr_req_i && bus.data_req_i) begin eg_d = ~m_last; eg_i = m_last; end
        else begin eg_i = bus.instr_req_i; eg_d = bus.data_req_i; end
      end
      checks++;
      if ({bus.instr_gnt_o, bus.data_gnt_o, bus.wb_cyc_o, bus.wb_stb_o} !== {eg_i, eg_d, m_busy, m_busy}) begin
        errors++;
        $display("FAIL rnd_ctl t=%0d got ig/dg/cyc/stb=%b want %b", t,
                 {bus.instr_gnt_o, bus.data_gnt_o, bus.wb_cyc_o, bus.wb_stb_o}, {eg_i, eg_d, m_busy, m_busy});
      end
      if (m_busy) begin
        checks++;
        if ({bus.wb_adr_o, bus.wb_sel_o, bus.wb_we_o} !== {m_adr, m_sel, m_we} || (m_owner && bus.wb_dat_o !== m_dat)) begin
          errors++;
          $display("FAIL rnd_bus t=%0d got adr=%h sel=%h we=%b dat=%h want %h %h %b %h", t, bus.wb_adr_o,
                   bus.wb_sel_o, bus.wb_we_o, bus.wb_dat_o, m_adr, m_sel, m_we, m_dat);
        end
      end
      checks++;
      if ({bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.data_err_o} !==
          {r_v && !r_o, r_v && !r_o && r_e, r_v && r_o, r_v && r_o && r_e} ||
          bus.instr_rdata_o !== m_rdata[0] || bus.data_rdata_o !== m_rdata[1]) begin
        errors++;
        $display("FAIL rnd_resp t=%0d got irv=%b ierr=%b drv=%b derr=%b ir=%h dr=%h want v=%b own=%b err=%b ir=%h dr=%h",
                 t, bus.instr_rvalid_o, bus.instr_err_o, bus.data_rvalid_o, bus.data_err_o,
                 bus.instr_rdata_o, bus.data_rdata_o, r_v, r_o, r_e, m_rdata[0], m_rdata[1]);
      end
      r_v = 0;
      if (m_busy) begin
        m_cnt++;
        if (bus.wb_ack_i) begin
          r_v = 1; r_o = m_owner; r_e = 0; m_rdata[m_owner] = bus.wb_dat_i; m_busy = 0;
        end else if (m_cnt == TMO) begin
          r_v = 1; r_o = m_owner; r_e = 1; m_rdata[m_owner] = '0; m_busy = 0;
        end
      end else if (eg_i || eg_d) begin
        m_busy = 1; m_owner = eg_d; m_last = eg_d; m_cnt = 0; m_lat = int'($urandom_range(TMO));
        if (eg_d) begin
          m_adr = {bus.data_addr_i[31:2], 2'b00}; m_sel = bus.data_be_i;
          m_we = bus.data_we_i; m_dat = bus.data_wdata_i;
        end else begin
          m_adr = {bus.instr_addr_i[31:2], 2'b00}; m_sel = 4'hF; m_we = 1'b0;
        end
      end
      next_cycle();
      if (eg_i) bus.instr_req_i = 1'b0;
      if (eg_d) bus.data_req_i = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_tie();
    test_byte_store();
    test_wait_states();
    test_timeout();
    test_reset_mid_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
